icmp_reply_ctrl: RTL and testbench

Sequencer between the ICMP receive parser and the ICMP transmit engine in the Ethernet path. It captures each completed echo request (identifier, sequence number, reply checksum, payload length) and launches one echo reply per request. It holds at most one further request while a reply is in flight, and drops anything beyond that. A watchdog recovers from a transmitter that never reports completion.

---
 rtl/icmp_reply_ctrl_if.sv | 32 +++
 rtl/icmp_reply_ctrl.sv | 151 +++++++++++++++
 tb/tb_icmp_reply_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icmp_reply_ctrl_if.sv
// Handshake bundle between the ICMP parser/transmitter side and the reply sequencer.
// The master drives captured requests and tx_done; the slave (sequencer) drives reply fields and status.
interface icmp_reply_ctrl_if;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [15:0] icmp_id;
    logic [15:0] icmp_seq;
    logic [31:0] reply_checksum;
    logic        tx_done;

    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [15:0] tx_icmp_id;
    logic [15:0] tx_icmp_seq;
    logic [31:0] tx_checksum;
    logic        busy;
    logic [15:0] reply_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] timeout_cnt;

    modport master (
        output rec_pkt_done, rec_byte_num, icmp_id, icmp_seq, reply_checksum, tx_done,
        input  tx_start_en, tx_byte_num, tx_icmp_id, tx_icmp_seq, tx_checksum,
        input  busy, reply_cnt, drop_cnt, timeout_cnt
    );

    modport slave (
        input  rec_pkt_done, rec_byte_num, icmp_id, icmp_seq, reply_checksum, tx_done,
        output tx_start_en, tx_byte_num, tx_icmp_id, tx_icmp_seq, tx_checksum,
        output busy, reply_cnt, drop_cnt, timeout_cnt
    );
endinterface

// File: rtl/icmp_reply_ctrl.sv
// Echo-reply sequencer: launches one reply per accepted request, buffers one extra request,
// and abandons a reply whose transmitter never reports completion.
module icmp_reply_ctrl #(
    parameter logic [15:0] TIMEOUT  = 16'd50000,
    parameter logic [15:0] MAX_BYTE = 16'd1472
) (
    input  logic              clk,
    input  logic              rst_n,
    icmp_reply_ctrl_if.slave  ctrl_if
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t      state_q;
    logic        slotValid_q;
    logic [15:0] slotLen_q;
    logic [15:0] slotId_q;
    logic [15:0] slotSeq_q;
    logic [31:0] slotChk_q;
    logic [15:0] wdog_q;
    logic        start_q;
    logic        busy_q;
    logic [15:0] txLen_q;
    logic [15:0] txId_q;
    logic [15:0] txSeq_q;
    logic [31:0] txChk_q;
    logic [15:0] replyCnt_q;
    logic [15:0] dropCnt_q;
    logic [15:0] timeoutCnt_q;

    logic reqOk;
    logic replyEnd;
    logic wdogExpire;
    logic dropEvent;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign reqOk      = ctrl_if.rec_pkt_done && (ctrl_if.rec_byte_num != 16'd0) &&
                        (ctrl_if.rec_byte_num <= MAX_BYTE);
    assign replyEnd   = (state_q == WAIT_DONE) && (ctrl_if.tx_done || (wdog_q == TIMEOUT - 16'd1));
    assign wdogExpire = replyEnd && !ctrl_if.tx_done;
    // A good request is only lost when it meets a full slot that is not being drained this cycle.
    assign dropEvent  = (ctrl_if.rec_pkt_done && !reqOk) ||
                        (reqOk && slotValid_q && (state_q != IDLE) && !replyEnd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slotValid_q  <= 1'b0;
            slotLen_q    <= '0;
            slotId_q     <= '0;
            slotSeq_q    <= '0;
            slotChk_q    <= '0;
            wdog_q       <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            txLen_q      <= '0;
            txId_q       <= '0;
            txSeq_q      <= '0;
            txChk_q      <= '0;
            replyCnt_q   <= '0;
            dropCnt_q    <= '0;
            timeoutCnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            if (dropEvent) dropCnt_q <= satInc(dropCnt_q);
            case (state_q)
                IDLE: begin
                    if (reqOk) begin
                        txLen_q <= ctrl_if.rec_byte_num;
                        txId_q  <= ctrl_if.icmp_id;
                        txSeq_q <= ctrl_if.icmp_seq;
                        txChk_q <= ctrl_if.reply_checksum;
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    replyCnt_q <= satInc(replyCnt_q);
                    wdog_q     <= '0;
                    state_q    <= WAIT_DONE;
                    if (reqOk && !slotValid_q) begin
                        slotValid_q <= 1'b1;
                        slotLen_q   <= ctrl_if.rec_byte_num;
                        slotId_q    <= ctrl_if.icmp_id;
                        slotSeq_q   <= ctrl_if.icmp_seq;
                        slotChk_q   <= ctrl_if.reply_checksum;
                    end
                end
                WAIT_DONE: begin
                    if (replyEnd) begin
                        if (wdogExpire) timeoutCnt_q <= satInc(timeoutCnt_q);
                        if (slotValid_q) begin
                            // Older slot entry goes out first; a simultaneous request refills the slot.
                            txLen_q     <= slotLen_q;
                            txId_q      <= slotId_q;
                            txSeq_q     <= slotSeq_q;
                            txChk_q     <= slotChk_q;
                            state_q     <= START;
                            start_q     <= 1'b1;
                            slotValid_q <= reqOk;
                            if (reqOk) begin
                                slotLen_q <= ctrl_if.rec_byte_num;
                                slotId_q  <= ctrl_if.icmp_id;
                                slotSeq_q <= ctrl_if.icmp_seq;
                                slotChk_q <= ctrl_if.reply_checksum;
                            end
                        end else if (reqOk) begin
                            txLen_q <= ctrl_if.rec_byte_num;
                            txId_q  <= ctrl_if.icmp_id;
                            txSeq_q <= ctrl_if.icmp_seq;
                            txChk_q <= ctrl_if.reply_checksum;
                            state_q <= START;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                        if (reqOk && !slotValid_q) begin
                            slotValid_q <= 1'b1;
                            slotLen_q   <= ctrl_if.rec_byte_num;
                            slotId_q    <= ctrl_if.icmp_id;
                            slotSeq_q   <= ctrl_if.icmp_seq;
                            slotChk_q   <= ctrl_if.reply_checksum;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_if.tx_start_en = start_q;
    assign ctrl_if.tx_byte_num = txLen_q;
    assign ctrl_if.tx_icmp_id  = txId_q;
    assign ctrl_if.tx_icmp_seq = txSeq_q;
    assign ctrl_if.tx_checksum = txChk_q;
    assign ctrl_if.busy        = busy_q;
    assign ctrl_if.reply_cnt   = replyCnt_q;
    assign ctrl_if.drop_cnt    = dropCnt_q;
    assign ctrl_if.timeout_cnt = timeoutCnt_q;

endmodule

// File: tb/tb_icmp_reply_ctrl.sv
// Bench for icmp_reply_ctrl: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a request-queue model of the reply sequencer.
module tb_icmp_reply_ctrl;
    localparam int TIMEOUT_T = 16;
    localparam int MAX_T     = 1472;

    typedef struct {
        logic [15:0] len;
        logic [15:0] id;
        logic [15:0] seq;
        logic [31:0] chk;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;

    icmp_reply_ctrl_if bus();

    icmp_reply_ctrl #(
        .TIMEOUT (16'(TIMEOUT_T)),
        .MAX_BYTE(16'(MAX_T))
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctrl_if(bus.slave)
    );

    always #5 clk = ~clk;

    // Model: a reply is either being launched, in flight (with its age in cycles), or absent.
    bit   mLaunch;
    bit   mActive;
    int   mAge;
    req_t pendQ[$];
    req_t mCur;
    int   mReply;
    int   mDrop;
    int   mTimeout;

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic resetModel();
        mLaunch  = 1'b0;
        mActive  = 1'b0;
        mAge     = 0;
        pendQ.delete();
        mCur     = '{16'd0, 16'd0, 16'd0, 32'd0};
        mReply   = 0;
        mDrop    = 0;
        mTimeout = 0;
    endtask

    task automatic modelStep(input bit req, input req_t r, input bit done);
        bit ok;
        bit ending;
        bit launchNext;
        ok         = req && (r.len >= 1) && (int'(r.len) <= MAX_T);
        ending     = mActive && (done || mAge == TIMEOUT_T);
        launchNext = 1'b0;
        if (req && !ok) mDrop = sat16(mDrop);
        if (mLaunch) begin
            mReply = sat16(mReply);
            if (ok) begin
                if (pendQ.size() == 0) pendQ.push_back(r);
                else mDrop = sat16(mDrop);
            end
        end else if (ending) begin
            if (!done) mTimeout = sat16(mTimeout);
            if (pendQ.size() > 0) begin
                mCur = pendQ.pop_front();
                launchNext = 1'b1;
                if (ok) pendQ.push_back(r);
            end else if (ok) begin
                mCur = r;
                launchNext = 1'b1;
            end
        end else if (mActive) begin
            if (ok) begin
                if (pendQ.size() == 0) pendQ.push_back(r);
                else mDrop = sat16(mDrop);
            end
        end else if (ok) begin
            mCur = r;
            launchNext = 1'b1;
        end
        if (launchNext) begin
            mLaunch = 1'b1;
            mActive = 1'b0;
            mAge    = 0;
        end else if (mLaunch) begin
            mLaunch = 1'b0;
            mActive = 1'b1;
            mAge    = 1;
        end else if (ending) begin
            mActive = 1'b0;
        end else begin
            mAge++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model advances on the same edge the DUT samples.
    task automatic applyStimulus(input bit req, input logic [15:0] len, input logic [15:0] id,
                                 input logic [15:0] seq, input logic [31:0] chk, input bit done);
        req_t r;
        r = '{len, id, seq, chk};
        bus.rec_pkt_done   = req;
        bus.rec_byte_num   = len;
        bus.icmp_id        = id;
        bus.icmp_seq       = seq;
        bus.reply_checksum = chk;
        bus.tx_done        = done;
        @(posedge clk);
        modelStep(req, r, done);
        #1;
        bus.rec_pkt_done = 1'b0;
        bus.tx_done      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 32'd0, 1'b0);
    endtask

    task automatic sendReq(input logic [15:0] len, input logic [15:0] id, input logic [15:0] seq,
                           input logic [31:0] chk);
        applyStimulus(1'b1, len, id, seq, chk, 1'b0);
    endtask

    task automatic txDone();
        applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 32'd0, 1'b1);
    endtask

    always @(negedge clk) begin
        checkOutput("tx_start_en", 32'(bus.tx_start_en), 32'(mLaunch));
        checkOutput("busy",        32'(bus.busy),        32'(mLaunch | mActive));
        checkOutput("tx_byte_num", 32'(bus.tx_byte_num), 32'(mCur.len));
        checkOutput("tx_icmp_id",  32'(bus.tx_icmp_id),  32'(mCur.id));
        checkOutput("tx_icmp_seq", 32'(bus.tx_icmp_seq), 32'(mCur.seq));
        checkOutput("tx_checksum", bus.tx_checksum,      mCur.chk);
        checkOutput("reply_cnt",   32'(bus.reply_cnt),   32'(mReply));
        checkOutput("drop_cnt",    32'(bus.drop_cnt),    32'(mDrop));
        checkOutput("timeout_cnt", 32'(bus.timeout_cnt), 32'(mTimeout));
    end

    initial begin
        bus.rec_pkt_done   = 1'b0;
        bus.rec_byte_num   = '0;
        bus.icmp_id        = '0;
        bus.icmp_seq       = '0;
        bus.reply_checksum = '0;
        bus.tx_done        = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_start", 32'(bus.tx_start_en), 32'd0);
        checkOutput("rst_busy",  32'(bus.busy),        32'd0);
        checkOutput("rst_chk",   bus.tx_checksum,      32'd0);
        checkOutput("rst_reply", 32'(bus.reply_cnt),   32'd0);
        rst_n = 1'b1;
        idle(5);

        $display("[TB] single request");
        sendReq(16'd32, 16'h0001, 16'h0005, 32'h0001_2345);
        checkOutput("t1_start", 32'(bus.tx_start_en), 32'd1);
        checkOutput("t1_id",    32'(bus.tx_icmp_id),  32'h0001);
        checkOutput("t1_seq",   32'(bus.tx_icmp_seq), 32'h0005);
        checkOutput("t1_chk",   bus.tx_checksum,      32'h0001_2345);
        checkOutput("t1_len",   32'(bus.tx_byte_num), 32'd32);
        idle(1);
        checkOutput("t1_pulse", 32'(bus.tx_start_en), 32'd0);
        checkOutput("t1_reply", 32'(bus.reply_cnt),   32'd1);
        idle(3);
        txDone();
        checkOutput("t1_busy",  32'(bus.busy),        32'd0);

        $display("[TB] three requests during a reply");
        sendReq(16'd64, 16'h0002, 16'd1, 32'h0000_1111);
        sendReq(16'd64, 16'h0002, 16'd2, 32'h0000_2222);
        sendReq(16'd64, 16'h0002, 16'd3, 32'h0000_3333);
        checkOutput("t2_drop",  32'(bus.drop_cnt),    32'd1);
        idle(2);
        txDone();
        checkOutput("t2_start", 32'(bus.tx_start_en), 32'd1);
        checkOutput("t2_seq",   32'(bus.tx_icmp_seq), 32'd2);
        checkOutput("t2_reply", 32'(bus.reply_cnt),   32'd2);
        idle(2);
        txDone();
        idle(1);

        $display("[TB] request coincident with tx_done");
        sendReq(16'd100, 16'h0003, 16'd8, 32'h0000_0008);
        sendReq(16'd100, 16'h0003, 16'd9, 32'h0000_0009);
        idle(2);
        applyStimulus(1'b1, 16'd100, 16'h0003, 16'd10, 32'h0000_000A, 1'b1);
        checkOutput("t3_start", 32'(bus.tx_start_en), 32'd1);
        checkOutput("t3_seq",   32'(bus.tx_icmp_seq), 32'd9);
        checkOutput("t3_drop",  32'(bus.drop_cnt),    32'd1);
        idle(2);
        txDone();
        checkOutput("t3_seq10", 32'(bus.tx_icmp_seq), 32'd10);
        idle(2);
        txDone();
        idle(1);

        $display("[TB] out-of-range lengths");
        sendReq(16'd0, 16'h0004, 16'd11, 32'h0);
        sendReq(16'(MAX_T + 1), 16'h0004, 16'd12, 32'h0);
        checkOutput("t4_drop",  32'(bus.drop_cnt),    32'd3);
        checkOutput("t4_busy",  32'(bus.busy),        32'd0);
        checkOutput("t4_start", 32'(bus.tx_start_en), 32'd0);
        idle(2);

        $display("[TB] watchdog expiry");
        sendReq(16'd200, 16'h0005, 16'd20, 32'h0002_0000);
        checkOutput("t5_start", 32'(bus.tx_start_en), 32'd1);
        sendReq(16'd200, 16'h0005, 16'd21, 32'h0002_0001);
        idle(TIMEOUT_T - 1);
        checkOutput("t5_nostart", 32'(bus.tx_start_en), 32'd0);
        checkOutput("t5_busy",    32'(bus.busy),        32'd1);
        idle(1);
        checkOutput("t5_restart", 32'(bus.tx_start_en), 32'd1);
        checkOutput("t5_seq",     32'(bus.tx_icmp_seq), 32'd21);
        checkOutput("t5_tmo",     32'(bus.timeout_cnt), 32'd1);
        idle(2);
        txDone();
        idle(1);

        $display("[TB] reset during reply");
        sendReq(16'd300, 16'h0006, 16'd30, 32'h0003_0000);
        sendReq(16'd300, 16'h0006, 16'd31, 32'h0003_0001);
        idle(3);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("t6_busy",  32'(bus.busy),        32'd0);
        checkOutput("t6_seq",   32'(bus.tx_icmp_seq), 32'd0);
        checkOutput("t6_reply", 32'(bus.reply_cnt),   32'd0);
        checkOutput("t6_tmo",   32'(bus.timeout_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        checkOutput("t6_nostart", 32'(bus.tx_start_en), 32'd0);
        sendReq(16'd48, 16'h0007, 16'd40, 32'h0004_0000);
        checkOutput("t6_start",   32'(bus.tx_start_en), 32'd1);
        checkOutput("t6_seq40",   32'(bus.tx_icmp_seq), 32'd40);
        idle(2);
        txDone();
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            bit          req;
            bit          done;
            logic [15:0] len;
            req  = ($urandom_range(0, 99) < 35);
            done = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 5))
                0:       len = 16'd0;
                1:       len = 16'(MAX_T);
                2:       len = 16'(MAX_T + 1);
                3:       len = 16'd1;
                default: len = 16'($urandom_range(1, 1600));
            endcase
            applyStimulus(req, len, 16'($urandom), 16'($urandom), $urandom, done);
        end
        idle(TIMEOUT_T + 4);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
